// File: rtl/plm_bank_array.sv
// plm_bank_array: banked private local memory fed by per-kernel scheduler words.
// Kernel k owns port k%NPORTS of bank k/NPORTS. Reads return data to the consumer
// named by the grant tag that travels with the request word.
// Optional feature macro: PLM_OUTPUT_REG_EN adds an output register stage on
// resp_value/resp_valid, which makes the read latency two cycles instead of one.
module plm_bank_array #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 2,
  localparam int NKERNELS   = NBANKS * NPORTS,
  localparam int LADDR      = ADDR_WIDTH - $clog2(NBANKS),
  localparam int WORD_W     = LADDR + VALUE_WIDTH + 1,
  localparam int ID_W       = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NKERNELS-1:0][WORD_W-1:0]        in,
  input  logic [NKERNELS-1:0]                    grant_valid,
  input  logic [NKERNELS-1:0][ID_W-1:0]          grant_id,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_value,
  output logic [NCONSUMERS-1:0]                  resp_valid,
  output logic                                   conflict
);

  // Table of which encodable grant tags name a real consumer.
  function automatic logic [2**ID_W-1:0] legalIds();
    logic [2**ID_W-1:0] legal;
    legal = '0;
    for (int i = 0; i < 2**ID_W; i++) begin
      legal[i] = (i < NCONSUMERS);
    end
    return legal;
  endfunction

  localparam logic [2**ID_W-1:0] ID_LEGAL = legalIds();

  logic [VALUE_WIDTH-1:0] mem [NBANKS][2**LADDR];

  logic [NKERNELS-1:0]                    reqWe;
  logic [NKERNELS-1:0]                    reqOk;
  logic [NKERNELS-1:0][LADDR-1:0]         reqAddr;
  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   reqData;

  logic [NCONSUMERS-1:0]                  respValid_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] respValue_d;
  logic                                   conflict_d;

  logic [NCONSUMERS-1:0]                  respValid_q;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] respValue_q;
  logic                                   conflict_q;

  // Split each scheduler word into its fields; a request only counts when its tag is legal.
  always_comb begin
    for (int k = 0; k < NKERNELS; k++) begin
      reqWe[k]   = in[k][WORD_W-1];
      reqAddr[k] = in[k][WORD_W-2 -: LADDR];
      reqData[k] = in[k][VALUE_WIDTH-1:0];
      reqOk[k]   = grant_valid[k] && ID_LEGAL[grant_id[k]];
    end
  end

  // Route reads to consumers (lowest kernel wins a shared tag) and detect every error case.
  always_comb begin
    respValid_d = '0;
    respValue_d = '0;
    conflict_d  = 1'b0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (grant_valid[k] && !ID_LEGAL[grant_id[k]]) begin
        conflict_d = 1'b1;
      end
      if (reqOk[k] && !reqWe[k]) begin
        if (respValid_d[grant_id[k]]) begin
          conflict_d = 1'b1;
        end else begin
          respValid_d[grant_id[k]] = 1'b1;
          respValue_d[grant_id[k]] = mem[k / NPORTS][reqAddr[k]];
        end
      end
    end
    for (int k = 0; k < NKERNELS; k++) begin
      for (int j = k + 1; j < NKERNELS; j++) begin
        if ((k / NPORTS) == (j / NPORTS) && reqOk[k] && reqOk[j] &&
            reqWe[k] && reqWe[j] && reqAddr[k] == reqAddr[j]) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Storage update; scanning ports high to low lets the lowest port land last and win, reset only blocks writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else begin
      for (int k = NKERNELS - 1; k >= 0; k--) begin
        if (reqOk[k] && reqWe[k]) begin
          mem[k / NPORTS][reqAddr[k]] <= reqData[k];
        end
      end
    end
  end

  // First response stage plus the sticky conflict flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respValid_q <= '0;
      respValue_q <= '0;
      conflict_q  <= 1'b0;
    end else begin
      respValid_q <= respValid_d;
      respValue_q <= respValue_d;
      conflict_q  <= conflict_q | conflict_d;
    end
  end

`ifdef PLM_OUTPUT_REG_EN
  logic [NCONSUMERS-1:0]                  respValidOut_q;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] respValueOut_q;

  // Extra output stage; conflict deliberately bypasses it so its timing does not move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respValidOut_q <= '0;
      respValueOut_q <= '0;
    end else begin
      respValidOut_q <= respValid_q;
      respValueOut_q <= respValue_q;
    end
  end

  assign resp_valid = respValidOut_q;
  assign resp_value = respValueOut_q;
`else
  assign resp_valid = respValid_q;
  assign resp_value = respValue_q;
`endif

  assign conflict = conflict_q;

endmodule

// File: tb/tb_plm_bank_array.sv
// tb_plm_bank_array: directed bench for plm_bank_array at default parameters,
// with a behavioural model of memory contents, response routing and error flag.
module tb_plm_bank_array;

`ifdef PLM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0][12:0] inWords = '0;
  logic [1:0] grantValid = '0;
  logic [1:0][0:0] grantId = '0;
  logic [1:0][7:0] respValue;
  logic [1:0] respValid;
  logic conflict;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  logic [7:0] mdlMem [16];
  logic [1:0] expValid, pipeValid, newValid;
  logic [1:0][7:0] expValue, pipeValue, newValue;
  logic expConflict;
  logic [15:0] written;
  logic [7:0] seen [$];

  always #5 clk = ~clk;

  plm_bank_array dut (
    .clk(clk),
    .reset(reset),
    .in(inWords),
    .grant_valid(grantValid),
    .grant_id(grantId),
    .resp_value(respValue),
    .resp_valid(respValid),
    .conflict(conflict)
  );

  // Behavioural model: reads see the old contents, then writes apply with the first writer of an address winning.
  initial begin
    expValid = '0; expValue = '0; pipeValid = '0; pipeValue = '0; expConflict = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        expValid = '0; expValue = '0; pipeValid = '0; pipeValue = '0; expConflict = 1'b0;
      end else begin
        newValid = '0; newValue = '0; written = '0;
        for (int k = 0; k < 2; k++) begin
          if (grantValid[k] && !inWords[k][12]) begin
            if (newValid[grantId[k]]) expConflict = 1'b1;
            else begin
              newValid[grantId[k]] = 1'b1;
              newValue[grantId[k]] = mdlMem[inWords[k][11:8]];
            end
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (grantValid[k] && inWords[k][12]) begin
            if (written[inWords[k][11:8]]) expConflict = 1'b1;
            else begin
              written[inWords[k][11:8]] = 1'b1;
              mdlMem[inWords[k][11:8]] = inWords[k][7:0];
            end
          end
        end
`ifdef PLM_OUTPUT_REG_EN
        expValid = pipeValid; expValue = pipeValue;
        pipeValid = newValid; pipeValue = newValue;
`else
        expValid = newValid; expValue = newValue;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle once out of reset, the DUT outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("cyc_resp_valid", 32'(respValid), 32'(expValid));
        checkOutput("cyc_resp_value", 32'(respValue), 32'(expValue));
        checkOutput("cyc_conflict", 32'(conflict), 32'(expConflict));
      end
    end
  end

  function automatic logic [12:0] wr(input logic [3:0] a, input logic [7:0] v);
    return {1'b1, a, v};
  endfunction

  function automatic logic [12:0] rd(input logic [3:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  task automatic applyStimulus(input logic v0, input logic [12:0] w0, input logic id0,
                               input logic v1, input logic [12:0] w1, input logic id1);
    grantValid = {v1, v0};
    inWords[0] = w0;
    inWords[1] = w1;
    grantId[0] = id0;
    grantId[1] = id1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1'b1;
    #1;
    checkOutput("reset_resp_valid", 32'(respValid), 32'h0);
    checkOutput("reset_resp_value", 32'(respValue), 32'h0);
    checkOutput("reset_conflict", 32'(conflict), 32'h0);
    idle(1);

    applyStimulus(1'b1, wr(4'd3, 8'hA5), 1'b0, 1'b0, 13'h0, 1'b0);
    applyStimulus(1'b1, rd(4'd3), 1'b1, 1'b0, 13'h0, 1'b0);
    idle(LAT - 1);
    checkOutput("rd_after_wr_valid", 32'(respValid), 32'h2);
    checkOutput("rd_after_wr_value", 32'(respValue[1]), 32'hA5);

    applyStimulus(1'b1, wr(4'd5, 8'h22), 1'b0, 1'b0, 13'h0, 1'b0);
    applyStimulus(1'b1, wr(4'd5, 8'h11), 1'b0, 1'b1, rd(4'd5), 1'b0);
    idle(LAT - 1);
    checkOutput("read_first_valid", 32'(respValid), 32'h1);
    checkOutput("read_first_value", 32'(respValue[0]), 32'h22);
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b1, rd(4'd5), 1'b0);
    idle(LAT - 1);
    checkOutput("read_new_value", 32'(respValue[0]), 32'h11);

    applyStimulus(1'b1, rd(4'd3), 1'b1, 1'b1, rd(4'd5), 1'b0);
    idle(LAT - 1);
    checkOutput("dual_read_valid", 32'(respValid), 32'h3);
    checkOutput("dual_read_value", 32'(respValue), 32'hA511);
    checkOutput("dual_read_conflict", 32'(conflict), 32'h0);

    applyStimulus(1'b1, wr(4'd7, 8'h01), 1'b0, 1'b1, wr(4'd7, 8'h02), 1'b1);
    applyStimulus(1'b1, rd(4'd7), 1'b0, 1'b0, 13'h0, 1'b0);
    idle(LAT - 1);
    checkOutput("ww_winner_value", 32'(respValue[0]), 32'h01);
    checkOutput("ww_conflict", 32'(conflict), 32'h1);
    idle(3);
    checkOutput("ww_conflict_sticky", 32'(conflict), 32'h1);

    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("conflict_after_reset", 32'(conflict), 32'h0);

    applyStimulus(1'b1, rd(4'd3), 1'b0, 1'b1, rd(4'd5), 1'b0);
    idle(LAT - 1);
    checkOutput("resp_coll_valid", 32'(respValid), 32'h1);
    checkOutput("resp_coll_value", 32'(respValue[0]), 32'hA5);
    checkOutput("resp_coll_conflict", 32'(conflict), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(respValid), 32'h0);
    checkOutput("async_rst_value", 32'(respValue), 32'h0);
    checkOutput("async_rst_conflict", 32'(conflict), 32'h0);
    applyStimulus(1'b1, wr(4'd3, 8'hFF), 1'b0, 1'b0, 13'h0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, rd(4'd3), 1'b0, 1'b0, 13'h0, 1'b0);
    idle(LAT - 1);
    checkOutput("wr_in_reset_ignored", 32'(respValue[0]), 32'hA5);

    applyStimulus(1'b1, wr(4'd0, 8'h10), 1'b0, 1'b1, wr(4'd1, 8'h20), 1'b1);
    applyStimulus(1'b1, wr(4'd2, 8'h30), 1'b0, 1'b1, wr(4'd3, 8'h40), 1'b1);
    seen.delete();
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) applyStimulus(1'b1, rd(4'(i)), 1'b0, 1'b0, 13'h0, 1'b0);
      else idle(1);
      if (respValid[0]) seen.push_back(respValue[0]);
    end
    checkOutput("b2b_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checkOutput($sformatf("b2b_value%0d", i), 32'(seen[i]), 32'(8'h10 * (i + 1)));
    end

    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plm_bank_array.md
# plm_bank_array

Banked private local memory (PLM) that consumes the per-kernel request words produced by the round-robin scheduling kernel and returns read data to the consumers that issued them. It holds NBANKS independent banks of NPORTS ports each; every port executes one read or write per cycle. Read responses are routed back to the originating consumer by a grant tag that travels alongside each request word.

## Interface
- ADDR_WIDTH, 4: global address width; bank-local address width is LADDR = ADDR_WIDTH - $clog2(NBANKS)
- VALUE_WIDTH, 8: data word width
- NCONSUMERS, 2: number of requesting consumers
- NBANKS, 1: number of banks; must be a power of two
- NPORTS, 2: ports per bank; NKERNELS = NBANKS*NPORTS
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  [LADDR+VALUE_WIDTH+1] x NKERNELS  scheduler words; kernel k drives bank k/NPORTS, port k%NPORTS; bit MSB = we, next LADDR bits = local addr, low VALUE_WIDTH bits = write value
- grant_valid  input  1 x NKERNELS  word on kernel k is a live request
- grant_id  input  $clog2(NCONSUMERS) x NKERNELS  consumer that owns kernel k's request
- resp_value  output  VALUE_WIDTH x NCONSUMERS  read data per consumer
- resp_valid  output  1 x NCONSUMERS  resp_value valid this cycle
- conflict  output  1  sticky error flag

## Operation
- Storage: NBANKS arrays of 2^LADDR words; contents not cleared by reset.
- Kernel k with grant_valid=1, we=1: write value to bank[k/NPORTS][addr] at clock edge. No response generated.
- Kernel k with grant_valid=1, we=0: read bank[k/NPORTS][addr]; response delivered to consumer grant_id[k].
- grant_valid=0: port idle; no write, no response.
- Read-first: read and write to the same address in the same cycle (any ports of the bank) returns the old value.
- Write-write collision: two ports of one bank write the same address in the same cycle -> lowest port index wins; conflict sets.
- Response collision: two reads in one cycle tagged with the same grant_id -> lowest kernel index delivered, other dropped; conflict sets.
- grant_id >= NCONSUMERS with grant_valid=1: request (read or write) ignored; conflict sets.
- conflict is sticky; cleared only by reset.
- Each consumer's response pipeline is single-entry per stage; there is no backpressure and consumers must accept every resp_valid pulse.

## Timing
- Reset values: resp_valid=0, resp_value=0, conflict=0; in-flight pipeline entries discarded.
- Reset asserted mid-operation: writes sampled while reset=1 are ignored; pending responses dropped.
- Base read latency: request sampled at edge N -> resp_valid/resp_value asserted after edge N, held for exactly one cycle (until edge N+1).
- Writes visible to reads sampled at edge N+1 and later.
- Full throughput: one request per kernel per cycle, back-to-back, with no bubbles.
- conflict rises one cycle after the offending request edge.

## Configuration
- PLM_OUTPUT_REG_EN defined: adds an output register stage on resp_value/resp_valid. Read latency becomes 2 cycles, and responses still arrive one per cycle in order. conflict timing is unchanged.
- PLM_OUTPUT_REG_EN undefined: read latency is 1 cycle as above.

## Test plan
(Default parameters; word = {we, addr[3:0], value[7:0]}.)
- Reset, then idle inputs -> resp_valid=0 on both consumers, resp_value=0, conflict=0.
- Kernel0 writes 0xA5 to addr 3 (id 0); next cycle kernel0 reads addr 3 (id 1) -> one cycle later resp_valid[1]=1, resp_value[1]=0xA5, resp_valid[0]=0.
- Same cycle: kernel0 writes 0x11 to addr 5, kernel1 reads addr 5 (old 0x22) -> resp returns 0x22; a following read returns 0x11.
- Kernel0 and kernel1 both write addr 7 (0x01 and 0x02) -> readback 0x01, conflict=1, and conflict stays 1 until reset.
- Both kernels read, both tagged id 0 -> only kernel0's data on consumer 0, conflict=1; then assert reset -> conflict=0, resp_valid=0 immediately (asynchronously).
- With PLM_OUTPUT_REG_EN defined: back-to-back reads of addr 0..3 on kernel0 -> responses appear 2 cycles after each request, consecutive, in order.
